// File: rtl/hcsr04_pkg.sv
// hcsr04_pkg: shared types, default constants and helpers for the HC-SR04 distance filter.
//   state_t        : measurement FSM states (IDLE, MEAS, CAPT)
//   MAX_CM_DEF     : default upper bound of an accepted distance, cm
//   TIMEOUT_US_DEF : default watchdog limit in 1 us ticks
//   sat_inc8       : 8-bit increment that holds at 255
package hcsr04_pkg;

    typedef enum logic [1:0] {IDLE, MEAS, CAPT} state_t;

    localparam int MAX_CM_DEF     = 400;
    localparam int TIMEOUT_US_DEF = 30000;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/hcsr04_avg_ring.sv
// hcsr04_avg_ring: ring buffer with running sum producing a moving average of accepted samples.
//   PCLK        in   clock
//   PRESET      in   synchronous reset, active-low
//   clr         in   synchronous soft clear, active-high
//   i_wr        in   accept strobe, one cycle per accepted sample
//   i_din       in   sample written on i_wr
//   o_avg       out  registered average, updated the cycle after i_wr
//   o_valid     out  window filled since reset/clear (sticky)
//   o_upd       out  high on the cycle o_avg/o_valid load their next values
//   o_avg_nxt   out  value o_avg takes on the o_upd edge
//   o_valid_nxt out  value o_valid takes on the o_upd edge
module hcsr04_avg_ring #(
    parameter int DIST_W   = 9,
    parameter int WIN_LOG2 = 2
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              clr,
    input  logic              i_wr,
    input  logic [DIST_W-1:0] i_din,
    output logic [DIST_W-1:0] o_avg,
    output logic              o_valid,
    output logic              o_upd,
    output logic [DIST_W-1:0] o_avg_nxt,
    output logic              o_valid_nxt
);
    localparam int                WIN_N = 1 << WIN_LOG2;
    localparam logic [WIN_LOG2:0] WIN   = (WIN_LOG2 + 1)'(WIN_N);

    logic [DIST_W-1:0]          r_buf [WIN_N];
    logic [DIST_W+WIN_LOG2-1:0] r_sum;
    logic [WIN_LOG2:0]          r_fill;
    logic [WIN_LOG2-1:0]        r_ptr;
    logic                       r_upd;
    logic [DIST_W-1:0]          r_avg;
    logic                       r_valid;
    logic [DIST_W+WIN_LOG2-1:0] w_din_x;
    logic [DIST_W+WIN_LOG2-1:0] w_old_x;

    assign w_din_x     = {{WIN_LOG2{1'b0}}, i_din};
    assign w_old_x     = {{WIN_LOG2{1'b0}}, r_buf[r_ptr]};
    assign o_avg_nxt   = r_sum[DIST_W+WIN_LOG2-1:WIN_LOG2];
    assign o_valid_nxt = r_valid | (r_fill == WIN);
    assign o_avg       = r_avg;
    assign o_valid     = r_valid;
    assign o_upd       = r_upd;

    always_ff @(posedge PCLK) begin
        if (!PRESET || clr) begin
            for (int i = 0; i < WIN_N; i++) r_buf[i] <= '0;
            r_sum   <= '0;
            r_fill  <= '0;
            r_ptr   <= '0;
            r_upd   <= 1'b0;
            r_avg   <= '0;
            r_valid <= 1'b0;
        end else begin
            r_upd <= i_wr;
            if (i_wr) begin
                // Swap the oldest sample out of the running sum; the sum cannot overflow.
                r_buf[r_ptr] <= i_din;
                r_sum        <= r_sum + w_din_x - w_old_x;
                r_ptr        <= r_ptr + 1'b1;
                r_fill       <= (r_fill == WIN) ? r_fill : r_fill + 1'b1;
            end
            if (r_upd) begin
                r_avg   <= o_avg_nxt;
                r_valid <= o_valid_nxt;
            end
        end
    end

endmodule

// File: rtl/hcsr04_dist_filter.sv
// hcsr04_dist_filter: measurement-cycle FSM with watchdog, range check, moving average and
// hysteretic proximity alarm for the HC-SR04 ranging core.
// Optional macro HCSR04_FILT_MINMAX_EN enables min/max tracking of accepted samples.
//   PCLK         in   clock
//   PRESET       in   synchronous reset, active-low
//   tick_1us     in   1 us strobe
//   meas_start   in   trigger level; rising edge starts a measurement
//   meas_done    in   done strobe; dist_in valid the following cycle
//   dist_in      in   distance, cm
//   clr          in   synchronous soft clear, active-high (overrides everything)
//   thresh       in   alarm threshold, cm
//   avg_out      out  moving average
//   avg_valid    out  window filled since reset/clr
//   alarm        out  proximity alarm
//   timeout_cnt  out  saturating watchdog timeout count
//   reject_cnt   out  saturating out-of-range count
//   min_out      out  min accepted sample (macro only, else 0)
//   max_out      out  max accepted sample (macro only, else 0)
module hcsr04_dist_filter
    import hcsr04_pkg::*;
#(
    parameter int DIST_W     = 9,
    parameter int WIN_LOG2   = 2,
    parameter int TIMEOUT_US = TIMEOUT_US_DEF,
    parameter int MAX_CM     = MAX_CM_DEF,
    parameter int HYST_CM    = 2
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              tick_1us,
    input  logic              meas_start,
    input  logic              meas_done,
    input  logic [DIST_W-1:0] dist_in,
    input  logic              clr,
    input  logic [DIST_W-1:0] thresh,
    output logic [DIST_W-1:0] avg_out,
    output logic              avg_valid,
    output logic              alarm,
    output logic [7:0]        timeout_cnt,
    output logic [7:0]        reject_cnt,
    output logic [DIST_W-1:0] min_out,
    output logic [DIST_W-1:0] max_out
);
    localparam int                TW    = $clog2(TIMEOUT_US);
    localparam logic [TW-1:0]     TLAST = TW'(TIMEOUT_US - 1);
    localparam logic [DIST_W-1:0] MAX_V = DIST_W'(MAX_CM);
    localparam logic [DIST_W:0]   HYST  = (DIST_W + 1)'(HYST_CM);

    state_t            r_state;
    logic              r_prev;
    logic [TW-1:0]     r_tcnt;
    logic [7:0]        r_to;
    logic [7:0]        r_rej;
    logic              r_alarm;
    logic              w_acc;
    logic              w_upd;
    logic [DIST_W-1:0] w_avg_nxt;
    logic              w_valid_nxt;
    logic [DIST_W:0]   w_release;

    assign w_acc       = (r_state == CAPT) && (dist_in <= MAX_V);
    // One extra bit so thresh + HYST_CM never wraps.
    assign w_release   = {1'b0, thresh} + HYST;
    assign timeout_cnt = r_to;
    assign reject_cnt  = r_rej;
    assign alarm       = r_alarm;

    hcsr04_avg_ring #(.DIST_W(DIST_W), .WIN_LOG2(WIN_LOG2)) u_ring (
        .PCLK        (PCLK),
        .PRESET      (PRESET),
        .clr         (clr),
        .i_wr        (w_acc),
        .i_din       (dist_in),
        .o_avg       (avg_out),
        .o_valid     (avg_valid),
        .o_upd       (w_upd),
        .o_avg_nxt   (w_avg_nxt),
        .o_valid_nxt (w_valid_nxt)
    );

    always_ff @(posedge PCLK) begin
        if (!PRESET || clr) begin
            r_state <= IDLE;
            r_prev  <= 1'b0;
            r_tcnt  <= '0;
            r_to    <= '0;
            r_rej   <= '0;
            r_alarm <= 1'b0;
        end else begin
            r_prev <= meas_start;
            case (r_state)
                IDLE: if (meas_start && !r_prev) begin
                    r_state <= MEAS;
                    r_tcnt  <= '0;
                end
                // Done is tested first so it wins over a coincident timeout.
                MEAS: if (meas_done) r_state <= CAPT;
                      else if (tick_1us) begin
                          if (r_tcnt == TLAST) begin
                              r_state <= IDLE;
                              r_to    <= sat_inc8(r_to);
                          end else r_tcnt <= r_tcnt + 1'b1;
                      end
                CAPT: begin
                    r_state <= IDLE;
                    if (!w_acc) r_rej <= sat_inc8(r_rej);
                end
                default: r_state <= IDLE;
            endcase
            // Alarm follows the average being loaded this cycle, not the stale one.
            if (w_upd)
                r_alarm <= (w_valid_nxt && (w_avg_nxt < thresh)) ? 1'b1 :
                           ({1'b0, w_avg_nxt} >= w_release) ? 1'b0 : r_alarm;
        end
    end

`ifdef HCSR04_FILT_MINMAX_EN
    logic [DIST_W-1:0] r_min;
    logic [DIST_W-1:0] r_max;
    logic [DIST_W-1:0] r_smp;
    logic              r_have;

    assign min_out = r_min;
    assign max_out = r_max;

    always_ff @(posedge PCLK) begin
        if (clr) begin
            r_min  <= '0;
            r_max  <= '0;
            r_smp  <= '0;
            r_have <= 1'b0;
        end else if (!PRESET) begin
            r_min  <= '1;
            r_max  <= '0;
            r_smp  <= '0;
            r_have <= 1'b0;
        end else begin
            if (w_acc) r_smp <= dist_in;
            // The first sample after reset/clr loads both bounds regardless of their reset value.
            if (w_upd) begin
                r_have <= 1'b1;
                r_min  <= (!r_have || r_smp < r_min) ? r_smp : r_min;
                r_max  <= (!r_have || r_smp > r_max) ? r_smp : r_max;
            end
        end
    end
`else
    assign min_out = '0;
    assign max_out = '0;
`endif

endmodule

// File: tb/tb_hcsr04_dist_filter.sv
// tb_hcsr04_dist_filter: directed scoreboard bench for hcsr04_dist_filter (TIMEOUT_US=100, thresh=20).
module tb_hcsr04_dist_filter;
    localparam int DW = 9;

    logic          PCLK = 1'b0;
    logic          PRESET = 1'b0;
    logic          tick_1us = 1'b0;
    logic          meas_start = 1'b0;
    logic          meas_done = 1'b0;
    logic          clr = 1'b0;
    logic [DW-1:0] dist_in = '0;
    logic [DW-1:0] thresh = 9'd20;
    logic [DW-1:0] avg_out;
    logic          avg_valid;
    logic          alarm;
    logic [7:0]    timeout_cnt;
    logic [7:0]    reject_cnt;
    logic [DW-1:0] min_out;
    logic [DW-1:0] max_out;

    hcsr04_dist_filter #(.DIST_W(DW), .WIN_LOG2(2), .TIMEOUT_US(100), .MAX_CM(400), .HYST_CM(2)) dut (
        .PCLK        (PCLK),
        .PRESET      (PRESET),
        .tick_1us    (tick_1us),
        .meas_start  (meas_start),
        .meas_done   (meas_done),
        .dist_in     (dist_in),
        .clr         (clr),
        .thresh      (thresh),
        .avg_out     (avg_out),
        .avg_valid   (avg_valid),
        .alarm       (alarm),
        .timeout_cnt (timeout_cnt),
        .reject_cnt  (reject_cnt),
        .min_out     (min_out),
        .max_out     (max_out)
    );

    always #5 PCLK = ~PCLK;

    typedef struct {
        int avg;
        int valid;
        int alarm;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   m_buf[4];
    int   m_sum, m_fill, m_ptr, m_valid, m_alarm;

    task automatic step();
        @(posedge PCLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 4; i++) m_buf[i] = 0;
        m_sum = 0; m_fill = 0; m_ptr = 0; m_valid = 0; m_alarm = 0;
    endtask

    task automatic model_accept(input int d);
        int a;
        m_sum = m_sum + d - m_buf[m_ptr];
        m_buf[m_ptr] = d;
        m_ptr = (m_ptr + 1) % 4;
        if (m_fill < 4) m_fill++;
        if (m_fill == 4) m_valid = 1;
        a = m_sum / 4;
        if (m_valid == 1 && a < int'(thresh)) m_alarm = 1;
        else if (a >= int'(thresh) + 2) m_alarm = 0;
        sb.push_back('{a, m_valid, m_alarm});
    endtask

    task automatic run_meas(input int d);
        meas_start = 1'b1; step();
        meas_start = 1'b0; step();
        meas_done = 1'b1;  step();
        meas_done = 1'b0;  dist_in = DW'(d); step();
        step();
    endtask

    task automatic check_out(input string tag);
        exp_t e;
        e = sb.pop_front();
        chk({tag, "_avg"}, 32'(avg_out), e.avg);
        chk({tag, "_valid"}, 32'(avg_valid), e.valid);
        chk({tag, "_alarm"}, 32'(alarm), e.alarm);
    endtask

    task automatic capture(input int d, input string tag);
        if (d <= 400) model_accept(d);
        run_meas(d);
        if (d <= 400) check_out(tag);
    endtask

    task automatic start_edge();
        meas_start = 1'b1; step();
        meas_start = 1'b0; step();
    endtask

    initial begin
        model_clear();
        step(); step();
        PRESET = 1'b1;
        chk("rst_avg", 32'(avg_out), 0);
        chk("rst_valid", 32'(avg_valid), 0);
        chk("rst_alarm", 32'(alarm), 0);
        chk("rst_tmo", 32'(timeout_cnt), 0);
        chk("rst_rej", 32'(reject_cnt), 0);
`ifdef HCSR04_FILT_MINMAX_EN
        chk("rst_min", 32'(min_out), 511);
`else
        chk("rst_min", 32'(min_out), 0);
`endif
        chk("rst_max", 32'(max_out), 0);

        for (int i = 0; i < 4; i++) capture(100, "fill100");
        chk("spec_avg100", 32'(avg_out), 100);
        for (int i = 0; i < 4; i++) capture(10, "step10");
        chk("spec_alarm_set", 32'(alarm), 1);
        for (int i = 0; i < 4; i++) capture(22, "step22");
        chk("spec_alarm_clr", 32'(alarm), 0);

        start_edge();
        repeat (99) begin tick_1us = 1'b1; step(); tick_1us = 1'b0; step(); end
        chk("tmo_99", 32'(timeout_cnt), 0);
        tick_1us = 1'b1; step(); tick_1us = 1'b0; step();
        chk("tmo_100", 32'(timeout_cnt), 1);
        meas_done = 1'b1; step(); meas_done = 1'b0; dist_in = 9'd5; step(); step(); step();
        chk("idle_done_avg", 32'(avg_out), 22);
        chk("idle_done_rej", 32'(reject_cnt), 0);

        start_edge();
        repeat (99) begin tick_1us = 1'b1; step(); tick_1us = 1'b0; step(); end
        tick_1us = 1'b1; meas_done = 1'b1; step();
        tick_1us = 1'b0; meas_done = 1'b0; dist_in = 9'd50; model_accept(50); step(); step();
        check_out("race");
        chk("race_tmo", 32'(timeout_cnt), 1);

        run_meas(450);
        chk("rej1_cnt", 32'(reject_cnt), 1);
        chk("rej1_avg", 32'(avg_out), m_sum / 4);
        repeat (255) run_meas(450);
        chk("rej_sat", 32'(reject_cnt), 255);
        capture(m_buf[m_ptr], "after_rej");

        start_edge();
        clr = 1'b1; step(); clr = 1'b0;
        model_clear();
        chk("clr_avg", 32'(avg_out), 0);
        chk("clr_valid", 32'(avg_valid), 0);
        chk("clr_tmo", 32'(timeout_cnt), 0);
        chk("clr_rej", 32'(reject_cnt), 0);
        chk("clr_min", 32'(min_out), 0);
        meas_done = 1'b1; step(); meas_done = 1'b0; dist_in = 9'd60; step(); step(); step();
        chk("clr_nodone_avg", 32'(avg_out), 0);

        capture(40, "pre_rst");
        start_edge();
        meas_done = 1'b1; step();
        meas_done = 1'b0; dist_in = 9'd80; PRESET = 1'b0; step();
        PRESET = 1'b1;
        model_clear();
        chk("capt_rst_avg", 32'(avg_out), 0);
        step(); step();
        chk("capt_rst_avg2", 32'(avg_out), 0);
        chk("capt_rst_valid", 32'(avg_valid), 0);

        capture(30, "mm30");
        capture(5, "mm5");
        capture(300, "mm300");
`ifdef HCSR04_FILT_MINMAX_EN
        chk("min", 32'(min_out), 5);
        chk("max", 32'(max_out), 300);
`else
        chk("min", 32'(min_out), 0);
        chk("max", 32'(max_out), 0);
`endif
        chk("sb_empty", 32'(sb.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
